// File: rtl/pwm_capture.sv
// ============================================================================
// Module   : pwm_capture
// Brief    : Measures period/high time of an external PWM, reports 0..63 duty
// Revision : 1.0
// ============================================================================
`default_nettype none

module pwm_capture #(
    parameter int CNT_W       = 10,
    parameter int TIMEOUT     = 256,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [5:0]       level,
    output logic [CNT_W-1:0] hi_len,
    output logic [CNT_W-1:0] period,
    output logic             valid,
    output logic             locked,
    output logic             stuck_high,
    output logic             stuck_low
);

    localparam int               IDLE_W      = $clog2(TIMEOUT);
    localparam logic [IDLE_W-1:0] c_IDLE_MAX = IDLE_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  c_CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  c_LVL_SAT  = CNT_W'(63);
    localparam logic [5:0]        c_LVL_MAX  = 6'd63;

    typedef enum logic [1:0] {
        S_ACQ   = 2'd0,
        S_RUN   = 2'd1,
        S_STUCK = 2'd2
    } state_t;

    state_t r_state, w_state_nxt;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_pwm_d;
    logic [IDLE_W-1:0]      r_idle_cnt;
    logic [CNT_W-1:0]       r_per_cnt;
    logic [CNT_W-1:0]       r_hi_cnt;
    logic [5:0]             r_level;
    logic [CNT_W-1:0]       r_hi_len;
    logic [CNT_W-1:0]       r_period;
    logic                   r_valid;
    logic                   r_locked;
    logic                   r_stuck_high;
    logic                   r_stuck_low;

    logic w_pwm_s;
    logic w_rise;
    logic w_fall;
    logic w_edge;
    logic w_timeout;
    logic [5:0] w_hi_level;

    assign w_pwm_s    = r_sync[SYNC_STAGES-1];
    assign w_rise     = w_pwm_s & ~r_pwm_d;
    assign w_fall     = ~w_pwm_s & r_pwm_d;
    assign w_edge     = w_rise | w_fall;
    // An edge always wins over a simultaneous idle expiry.
    assign w_timeout  = ~w_edge & (r_idle_cnt == c_IDLE_MAX) & (r_state != S_STUCK);
    assign w_hi_level = (r_hi_cnt >= c_LVL_SAT) ? c_LVL_MAX : r_hi_cnt[5:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_ACQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_ACQ: begin
                if (w_rise)         w_state_nxt = S_RUN;
                else if (w_timeout) w_state_nxt = S_STUCK;
            end
            S_RUN: begin
                if (w_timeout)      w_state_nxt = S_STUCK;
            end
            S_STUCK: begin
                if (w_rise)         w_state_nxt = S_RUN;
                else if (w_fall)    w_state_nxt = S_ACQ;
            end
            default:                w_state_nxt = S_ACQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync       <= '0;
            r_pwm_d      <= 1'b0;
            r_idle_cnt   <= '0;
            r_per_cnt    <= '0;
            r_hi_cnt     <= '0;
            r_level      <= '0;
            r_hi_len     <= '0;
            r_period     <= '0;
            r_valid      <= 1'b0;
            r_locked     <= 1'b0;
            r_stuck_high <= 1'b0;
            r_stuck_low  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], pwm_in};
            r_pwm_d <= w_pwm_s;
            r_valid <= 1'b0;

            if (w_edge) begin
                r_idle_cnt <= '0;
            end else if (r_idle_cnt != c_IDLE_MAX) begin
                r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
            end

            if (w_timeout) begin
                r_stuck_high <= w_pwm_s;
                r_stuck_low  <= ~w_pwm_s;
                r_level      <= w_pwm_s ? c_LVL_MAX : 6'd0;
                r_valid      <= 1'b1;
                r_locked     <= 1'b0;
            end

            if (r_state == S_STUCK && w_edge) begin
                r_stuck_high <= 1'b0;
                r_stuck_low  <= 1'b0;
            end

            // The rise cycle itself is the first cycle of the new period.
            if (w_rise) begin
                r_per_cnt <= CNT_W'(1);
                r_hi_cnt  <= CNT_W'(1);
                if (r_state == S_RUN) begin
                    r_period <= r_per_cnt;
                    r_hi_len <= r_hi_cnt;
                    r_level  <= w_hi_level;
                    r_valid  <= 1'b1;
                    r_locked <= 1'b1;
                end
            end else if (r_state == S_RUN) begin
                if (r_per_cnt != c_CNT_MAX) r_per_cnt <= r_per_cnt + CNT_W'(1);
                if (r_hi_cnt != c_CNT_MAX)  r_hi_cnt  <= r_hi_cnt + CNT_W'(w_pwm_s);
            end
        end
    end

    assign level      = r_level;
    assign hi_len     = r_hi_len;
    assign period     = r_period;
    assign valid      = r_valid;
    assign locked     = r_locked;
    assign stuck_high = r_stuck_high;
    assign stuck_low  = r_stuck_low;

endmodule

`default_nettype wire

// File: tb/tb_pwm_capture.sv
// ============================================================================
// Module   : tb_pwm_capture
// Brief    : Directed + random PWM stimulus against a timestamp-based model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pwm_capture;

    localparam int P_CNT_W   = 8;
    localparam int P_TIMEOUT = 200;
    localparam int P_SYNC    = 3;
    localparam int P_CMAX    = (1 << P_CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               pwm_in = 1'b0;
    logic [5:0]         level;
    logic [P_CNT_W-1:0] hi_len;
    logic [P_CNT_W-1:0] period;
    logic               valid;
    logic               locked;
    logic               stuck_high;
    logic               stuck_low;

    int n_asserts = 0;
    int n_fail    = 0;

    pwm_capture #(
        .CNT_W      (P_CNT_W),
        .TIMEOUT    (P_TIMEOUT),
        .SYNC_STAGES(P_SYNC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pwm_in    (pwm_in),
        .level     (level),
        .hi_len    (hi_len),
        .period    (period),
        .valid     (valid),
        .locked    (locked),
        .stuck_high(stuck_high),
        .stuck_low (stuck_low)
    );

    always #5 clk = ~clk;

    // Model: the input as seen after the synchronizer, a sample window since
    // the last rise, and the clock index of the last edge (or reset).
    int n = 0;
    int last_evt = 0;
    bit inh[$];
    bit win[$];
    bit m_stuck, m_have_ref;
    int e_level, e_hi, e_per;
    bit e_valid, e_locked, e_sh, e_sl;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, n, obs, exp);
        end
    endtask

    task automatic check_all();
        check("level",      32'(level),      32'(e_level));
        check("hi_len",     32'(hi_len),     32'(e_hi));
        check("period",     32'(period),     32'(e_per));
        check("valid",      32'(valid),      32'(e_valid));
        check("locked",     32'(locked),     32'(e_locked));
        check("stuck_high", 32'(stuck_high), 32'(e_sh));
        check("stuck_low",  32'(stuck_low),  32'(e_sl));
    endtask

    task automatic model_reset();
        inh.delete();
        repeat (P_SYNC + 1) inh.push_back(1'b0);
        win.delete();
        last_evt   = n;
        m_stuck    = 1'b0;
        m_have_ref = 1'b0;
        e_level = 0; e_hi = 0; e_per = 0;
        e_valid = 1'b0; e_locked = 1'b0; e_sh = 1'b0; e_sl = 1'b0;
    endtask

    task automatic model_step(input bit din);
        bit x, xp, rise, fall, to;
        int hi;
        inh.push_back(din);
        x  = inh[1];
        xp = inh[0];
        void'(inh.pop_front());
        rise = x & ~xp;
        fall = ~x & xp;
        e_valid = 1'b0;
        to = !(rise || fall) && ((n - 1 - last_evt) >= P_TIMEOUT - 1) && !m_stuck;
        if (rise || fall) last_evt = n;
        if (to) begin
            m_stuck  = 1'b1;
            e_sh     = x;
            e_sl     = ~x;
            e_level  = x ? 63 : 0;
            e_valid  = 1'b1;
            e_locked = 1'b0;
        end
        if (rise) begin
            if (m_have_ref && !m_stuck) begin
                hi = 0;
                foreach (win[i]) hi += int'(win[i]);
                e_per    = (win.size() > P_CMAX) ? P_CMAX : win.size();
                e_hi     = (hi > P_CMAX) ? P_CMAX : hi;
                e_level  = (hi > 63) ? 63 : hi;
                e_valid  = 1'b1;
                e_locked = 1'b1;
            end
            m_have_ref = 1'b1;
            m_stuck    = 1'b0;
            e_sh = 1'b0;
            e_sl = 1'b0;
            win.delete();
            win.push_back(x);
        end else begin
            if (fall && m_stuck) begin
                m_stuck    = 1'b0;
                m_have_ref = 1'b0;
                e_sh = 1'b0;
                e_sl = 1'b0;
            end
            win.push_back(x);
        end
    endtask

    task automatic tick(input bit v);
        pwm_in = v;
        @(posedge clk);
        #1;
        n++;
        model_step(v);
        check_all();
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            n++;
        end
        model_reset();
        check_all();
        rst = 1'b0;
    endtask

    task automatic phase(input bit v, input int len);
        for (int i = 0; i < len; i++) tick(v);
    endtask

    initial begin
        bit lvl;
        do_reset(2);

        // Idle-low from reset
        phase(1'b0, P_TIMEOUT + 20);
        check("dir_stuck_low", 32'(stuck_low), 32'd1);
        check("dir_lvl0",      32'(level),     32'd0);

        // Reference 20
        repeat (5) begin
            phase(1'b1, 20);
            phase(1'b0, 44);
        end
        check("dir_per64", 32'(period), 32'd64);
        check("dir_hi20",  32'(hi_len), 32'd20);
        check("dir_lvl20", 32'(level),  32'd20);
        check("dir_lock",  32'(locked), 32'd1);

        // Reference 45
        repeat (3) begin
            phase(1'b1, 45);
            phase(1'b0, 19);
        end
        check("dir_hi45", 32'(hi_len), 32'd45);

        // Reset in the middle of a high phase
        phase(1'b1, 10);
        do_reset(1);
        phase(1'b1, 10);
        phase(1'b0, 19);
        repeat (2) begin
            phase(1'b1, 45);
            phase(1'b0, 19);
        end

        // Constant high
        phase(1'b1, P_TIMEOUT + 50);
        check("dir_stuck_high", 32'(stuck_high), 32'd1);
        check("dir_lvl63",      32'(level),      32'd63);
        check("dir_unlock",     32'(locked),     32'd0);
        phase(1'b0, 5);

        // Fastest pattern, then a long high phase
        repeat (12) begin
            phase(1'b1, 1);
            phase(1'b0, 2);
        end
        check("dir_per3", 32'(period), 32'd3);
        check("dir_hi1",  32'(hi_len), 32'd1);
        phase(1'b1, 80);
        phase(1'b0, 20);
        phase(1'b1, 1);
        phase(1'b0, 10);
        check("dir_hi80",  32'(hi_len), 32'd80);
        check("dir_lvlsat", 32'(level), 32'd63);

        // Period beyond counter range, phases below timeout
        repeat (2) begin
            phase(1'b1, 150);
            phase(1'b0, 150);
        end
        phase(1'b1, 10);
        check("dir_persat", 32'(period), 32'(P_CMAX));
        phase(1'b0, 10);

        // Random phases, some long enough to go stuck
        lvl = 1'b1;
        repeat (40) begin
            phase(lvl, $urandom_range(1, 260));
            lvl = ~lvl;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
